// File: rtl/hamming_decode_scheduler.sv
// Purpose: two-requester round-robin front end for a shared bit-serial Hamming(7,4) decoder.
// Latency: grant at T, dec_ena T+1..T+7 (LSB first), WAIT from T+8, rsp_valid no earlier than T+9.
// Backpressure: reqN_ready only in IDLE (one per grant); rsp_* is an unthrottled one-cycle pulse.
//
// Ports:
//   clk, rst                   rising-edge clock, synchronous active-high reset
//   reqN_valid/code/ready      requester N codeword handshake (N = 0, 1)
//   dec_ena, dec_bit           serial codeword stream to the decoder
//   dec_valid/data/syndrome    decoder result, sampled only while waiting
//   rsp_valid/id/data/err/timeout  response pulse back to the owning requester
//   err_count                  saturating count of responses with rsp_err set
//   busy                       high whenever a transaction is in flight
module hamming_decode_scheduler #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req0_valid,
  input  logic [6:0] req0_code,
  output logic       req0_ready,
  input  logic       req1_valid,
  input  logic [6:0] req1_code,
  output logic       req1_ready,
  output logic       dec_ena,
  output logic       dec_bit,
  input  logic       dec_valid,
  input  logic [3:0] dec_data,
  input  logic [2:0] dec_syndrome,
  output logic       rsp_valid,
  output logic       rsp_id,
  output logic [3:0] rsp_data,
  output logic       rsp_err,
  output logic       rsp_timeout,
  output logic [7:0] err_count,
  output logic       busy
);

  typedef enum logic [1:0] {IDLE, SHIFT, WAIT, RESP} state_t;

  // Counter value seen in the last WAIT cycle that may still accept a result.
  localparam logic [7:0] LAST_WAIT = 8'(TIMEOUT - 1);

  state_t     state_q;
  logic       last_q;       // id granted most recently; the other side wins a tie
  logic       id_q;
  logic [6:0] code_q;
  logic [2:0] bit_idx_q;
  logic [7:0] wait_cnt_q;
  logic [7:0] err_count_q;
  logic       dec_ena_q;
  logic       dec_bit_q;
  logic       busy_q;
  logic       rsp_valid_q;
  logic       rsp_id_q;
  logic [3:0] rsp_data_q;
  logic       rsp_err_q;
  logic       rsp_timeout_q;

  logic       grant_vld_d;
  logic       grant_id_d;
  logic [6:0] grant_code_d;

  // Grant decision is combinational so ready coincides with the accepting cycle.
  // rst masks it so nothing is accepted on a reset edge.
  always_comb begin
    grant_vld_d = (state_q == IDLE) && !rst && (req0_valid || req1_valid);
    if (req0_valid && req1_valid) begin
      grant_id_d = ~last_q;
    end else begin
      grant_id_d = req1_valid;
    end
    grant_code_d = grant_id_d ? req1_code : req0_code;
  end

  assign req0_ready = grant_vld_d && !grant_id_d;
  assign req1_ready = grant_vld_d &&  grant_id_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      last_q        <= 1'b1;
      id_q          <= 1'b0;
      code_q        <= '0;
      bit_idx_q     <= '0;
      wait_cnt_q    <= '0;
      err_count_q   <= '0;
      dec_ena_q     <= 1'b0;
      dec_bit_q     <= 1'b0;
      busy_q        <= 1'b0;
      rsp_valid_q   <= 1'b0;
      rsp_id_q      <= 1'b0;
      rsp_data_q    <= '0;
      rsp_err_q     <= 1'b0;
      rsp_timeout_q <= 1'b0;
    end else begin
      // Serial and response outputs are pulses; each state re-asserts what it needs.
      dec_ena_q     <= 1'b0;
      dec_bit_q     <= 1'b0;
      rsp_valid_q   <= 1'b0;
      rsp_id_q      <= 1'b0;
      rsp_data_q    <= '0;
      rsp_err_q     <= 1'b0;
      rsp_timeout_q <= 1'b0;

      case (state_q)
        IDLE: begin
          if (grant_vld_d) begin
            state_q   <= SHIFT;
            id_q      <= grant_id_d;
            last_q    <= grant_id_d;
            code_q    <= grant_code_d;
            bit_idx_q <= '0;
            busy_q    <= 1'b1;
            // Present bit 0 in the first SHIFT cycle.
            dec_ena_q <= 1'b1;
            dec_bit_q <= grant_code_d[0];
          end
        end

        SHIFT: begin
          if (bit_idx_q == 3'd6) begin
            state_q    <= WAIT;
            wait_cnt_q <= '0;
          end else begin
            bit_idx_q <= bit_idx_q + 3'd1;
            dec_ena_q <= 1'b1;
            dec_bit_q <= code_q[bit_idx_q + 3'd1];
          end
        end

        WAIT: begin
          wait_cnt_q <= wait_cnt_q + 8'd1;
          // A result in the final allowed cycle wins over the timeout.
          if (dec_valid) begin
            state_q     <= RESP;
            rsp_valid_q <= 1'b1;
            rsp_id_q    <= id_q;
            rsp_data_q  <= dec_data;
            rsp_err_q   <= |dec_syndrome;
          end else if (wait_cnt_q == LAST_WAIT) begin
            state_q       <= RESP;
            rsp_valid_q   <= 1'b1;
            rsp_id_q      <= id_q;
            rsp_timeout_q <= 1'b1;
          end
        end

        RESP: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          if (rsp_err_q && (err_count_q != 8'hFF)) begin
            err_count_q <= err_count_q + 8'd1;
          end
        end

        default: state_q <= IDLE;
      endcase
    end
  end

  assign dec_ena     = dec_ena_q;
  assign dec_bit     = dec_bit_q;
  assign busy        = busy_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_id      = rsp_id_q;
  assign rsp_data    = rsp_data_q;
  assign rsp_err     = rsp_err_q;
  assign rsp_timeout = rsp_timeout_q;
  assign err_count   = err_count_q;

endmodule

// File: tb/tb_hamming_decode_scheduler.sv
// Purpose: self-checking bench for hamming_decode_scheduler.
// Latency: inputs change 1 time unit after each rising edge; outputs are sampled on the falling edge.
// Backpressure: none modelled beyond the requester handshake.
module tb_hamming_decode_scheduler;

  localparam int TMO = 15;

  logic       clk = 1'b0;
  logic       rst;
  logic       req0_valid, req1_valid;
  logic [6:0] req0_code, req1_code;
  logic       req0_ready, req1_ready;
  logic       dec_ena, dec_bit;
  logic       dec_valid;
  logic [3:0] dec_data;
  logic [2:0] dec_syndrome;
  logic       rsp_valid, rsp_id, rsp_err, rsp_timeout, busy;
  logic [3:0] rsp_data;
  logic [7:0] err_count;

  always #5 clk = ~clk;

  hamming_decode_scheduler #(.TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_code(req0_code), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_code(req1_code), .req1_ready(req1_ready),
    .dec_ena(dec_ena), .dec_bit(dec_bit),
    .dec_valid(dec_valid), .dec_data(dec_data), .dec_syndrome(dec_syndrome),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data),
    .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
    .err_count(err_count), .busy(busy)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  typedef struct { int c; logic id; } gnt_t;
  typedef struct { int c; logic id; logic [3:0] data; logic err; logic tmo; } rsp_t;
  gnt_t gnt_log[$];
  rsp_t rsp_log[$];
  logic bits_log[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- transaction-level reference model ----------------
  // A transaction is described by its grant cycle and the offset (from the
  // grant) of its response cycle; all outputs follow from those offsets.
  bit         m_known = 1'b0;
  bit         m_act   = 1'b0;
  bit         m_last  = 1'b1;
  bit         m_id;
  logic [6:0] m_code;
  int         m_gcyc, m_roff, m_err;
  logic [3:0] m_rdata;
  bit         m_rerr, m_rtmo;

  logic [20:0] exp_v, act_v;
  int          off;
  bit          e_r0, e_r1, e_ena, e_bit, e_busy, e_rv, e_rid, e_rerr, e_rtmo;
  logic [3:0]  e_rdata;

  always @(negedge clk) begin
    cyc++;
    if (req0_ready) gnt_log.push_back('{cyc, 1'b0});
    if (req1_ready) gnt_log.push_back('{cyc, 1'b1});
    if (dec_ena)    bits_log.push_back(dec_bit);
    if (rsp_valid)  rsp_log.push_back('{cyc, rsp_id, rsp_data, rsp_err, rsp_timeout});

    if (m_known) begin
      {e_r0, e_r1, e_ena, e_bit, e_busy, e_rv, e_rid, e_rerr, e_rtmo} = '0;
      e_rdata = '0;
      if (m_act) begin
        off    = cyc - m_gcyc;
        e_busy = 1'b1;
        if (off >= 1 && off <= 7) begin
          e_ena = 1'b1;
          e_bit = m_code[off-1];
        end
        if (m_roff != 0 && off == m_roff) begin
          e_rv = 1'b1; e_rid = m_id; e_rdata = m_rdata; e_rerr = m_rerr; e_rtmo = m_rtmo;
        end
      end else if (!rst) begin
        if (req0_valid && req1_valid) begin
          e_r0 = (m_last == 1'b1);
          e_r1 = (m_last == 1'b0);
        end else begin
          e_r0 = req0_valid;
          e_r1 = req1_valid;
        end
      end
      exp_v = {e_r0, e_r1, e_ena, e_bit, e_busy, e_rv, e_rid, e_rdata, e_rerr, e_rtmo, m_err[7:0]};
      act_v = {req0_ready, req1_ready, dec_ena, dec_bit, busy, rsp_valid, rsp_id,
               rsp_data, rsp_err, rsp_timeout, err_count};
      check("cycle_outputs", 32'(act_v), 32'(exp_v));
    end

    if (rst) begin
      m_known = 1'b1; m_act = 1'b0; m_err = 0; m_last = 1'b1;
    end else if (m_known) begin
      if (!m_act) begin
        if (req0_valid || req1_valid) begin
          if (req0_valid && req1_valid) m_id = !m_last;
          else                          m_id = req1_valid;
          m_code = m_id ? req1_code : req0_code;
          m_last = m_id; m_act = 1'b1; m_gcyc = cyc; m_roff = 0;
        end
      end else begin
        off = cyc - m_gcyc;
        if (m_roff == 0 && off >= 8 && off <= 7 + TMO) begin
          if (dec_valid) begin
            m_roff = off + 1; m_rdata = dec_data; m_rerr = (dec_syndrome != 0); m_rtmo = 1'b0;
          end else if (off == 7 + TMO) begin
            m_roff = off + 1; m_rdata = 4'h0; m_rerr = 1'b0; m_rtmo = 1'b1;
          end
        end else if (m_roff != 0 && off == m_roff) begin
          m_act = 1'b0;
          if (m_rerr && m_err < 255) m_err++;
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    rst = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0;
    req0_code = 7'($urandom); req1_code = 7'($urandom);
    dec_valid = 1'b0; dec_data = 4'($urandom); dec_syndrome = 3'($urandom);
  endtask

  // Reset with random activity on every other input; rst must win.
  task automatic do_reset();
    for (int k = 0; k < 2; k++) begin
      tick();
      rst = 1'b1;
      req0_valid = 1'($urandom); req1_valid = 1'($urandom);
      dec_valid  = 1'($urandom);
    end
    tick();
    idle_inputs();
  endtask

  task automatic clear_logs();
    gnt_log.delete(); rsp_log.delete(); bits_log.delete();
  endtask

  logic [6:0] bits_v;
  logic [6:0] pat_1010101;

  initial begin
    rst = 1'b1; req0_valid = 0; req1_valid = 0; req0_code = 0; req1_code = 0;
    dec_valid = 0; dec_data = 0; dec_syndrome = 0;
    pat_1010101 = 7'b1010101;

    // Single requester, known codeword, decoder answers at the first WAIT cycle.
    do_reset(); clear_logs();
    for (int k = 0; k <= 12; k++) begin
      if (k > 0) tick();
      idle_inputs();
      req0_valid = (k < 4); req0_code = 7'b1010101;
      if (k == 8) begin dec_valid = 1'b1; dec_data = 4'hB; dec_syndrome = 3'b000; end
    end
    tick(); idle_inputs();
    check("a_grant_count", gnt_log.size(), 1);
    if (gnt_log.size() > 0) check("a_grant_id", gnt_log[0].id, 0);
    bits_v = '0;
    foreach (bits_log[i]) if (i < 7) bits_v[i] = bits_log[i];
    check("a_bit_count", bits_log.size(), 7);
    check("a_bit_seq", bits_v, pat_1010101);
    check("a_rsp_count", rsp_log.size(), 1);
    if (rsp_log.size() > 0 && gnt_log.size() > 0) begin
      check("a_rsp_id", rsp_log[0].id, 0);
      check("a_rsp_data", rsp_log[0].data, 4'hB);
      check("a_rsp_err", rsp_log[0].err, 0);
      check("a_rsp_tmo", rsp_log[0].tmo, 0);
      check("a_latency", rsp_log[0].c - gnt_log[0].c, 9);
    end

    // Both requesters held valid: grants alternate, back-to-back every 10 cycles.
    do_reset(); clear_logs();
    for (int k = 0; k <= 44; k++) begin
      if (k > 0) tick();
      idle_inputs();
      req0_valid = 1'b1; req1_valid = 1'b1; dec_valid = 1'b1; dec_syndrome = 3'b000;
    end
    tick(); idle_inputs();
    check("b_grant_count", gnt_log.size() >= 4, 1);
    check("b_rsp_count", rsp_log.size() >= 4, 1);
    if (gnt_log.size() >= 4 && rsp_log.size() >= 4) begin
      check("b_grant_ids", {gnt_log[0].id, gnt_log[1].id, gnt_log[2].id, gnt_log[3].id}, 4'b0101);
      check("b_rsp_ids", {rsp_log[0].id, rsp_log[1].id, rsp_log[2].id, rsp_log[3].id}, 4'b0101);
      check("b_grant_spacing", gnt_log[1].c - gnt_log[0].c, 10);
    end

    // One error response, then a silent decoder: timeout must not count as an error.
    do_reset(); clear_logs();
    for (int k = 0; k <= 36; k++) begin
      if (k > 0) tick();
      idle_inputs();
      req0_valid = (k == 0);
      req1_valid = (k == 10);
      if (k == 8) begin dec_valid = 1'b1; dec_data = 4'h3; dec_syndrome = 3'b010; end
    end
    tick(); idle_inputs();
    check("c_rsp_count", rsp_log.size(), 2);
    if (rsp_log.size() == 2 && gnt_log.size() == 2) begin
      check("c_first_err", rsp_log[0].err, 1);
      check("c_tmo_flag", rsp_log[1].tmo, 1);
      check("c_tmo_data", rsp_log[1].data, 0);
      check("c_tmo_err", rsp_log[1].err, 0);
      check("c_tmo_id", rsp_log[1].id, 1);
      check("c_tmo_latency", rsp_log[1].c - gnt_log[1].c, 8 + TMO);
    end
    @(negedge clk);
    check("c_err_count", err_count, 1);

    // Result in the very last allowed WAIT cycle is a real result.
    do_reset(); clear_logs();
    for (int k = 0; k <= 26; k++) begin
      if (k > 0) tick();
      idle_inputs();
      req0_valid = (k == 0);
      if (k == 7 + TMO) begin dec_valid = 1'b1; dec_data = 4'h6; dec_syndrome = 3'b000; end
    end
    tick(); idle_inputs();
    check("c2_rsp_count", rsp_log.size(), 1);
    if (rsp_log.size() > 0 && gnt_log.size() > 0) begin
      check("c2_tmo", rsp_log[0].tmo, 0);
      check("c2_data", rsp_log[0].data, 4'h6);
      check("c2_latency", rsp_log[0].c - gnt_log[0].c, 8 + TMO);
    end

    // Stray dec_valid while shifting is ignored; the WAIT result is returned.
    do_reset(); clear_logs();
    for (int k = 0; k <= 15; k++) begin
      if (k > 0) tick();
      idle_inputs();
      req0_valid = (k == 0);
      if (k == 3)  begin dec_valid = 1'b1; dec_data = 4'h5; dec_syndrome = 3'b001; end
      if (k == 12) begin dec_valid = 1'b1; dec_data = 4'h9; dec_syndrome = 3'b000; end
    end
    tick(); idle_inputs();
    check("d_rsp_count", rsp_log.size(), 1);
    if (rsp_log.size() > 0 && gnt_log.size() > 0) begin
      check("d_data", rsp_log[0].data, 4'h9);
      check("d_err", rsp_log[0].err, 0);
      check("d_latency", rsp_log[0].c - gnt_log[0].c, 13);
    end

    // Reset on the third SHIFT cycle aborts; a later req1 runs normally.
    do_reset(); clear_logs();
    for (int k = 0; k <= 3; k++) begin
      if (k > 0) tick();
      idle_inputs();
      req0_valid = (k == 0);
      rst = (k == 3);
    end
    tick(); idle_inputs();
    @(negedge clk);
    check("e_dec_ena_after_rst", dec_ena, 0);
    check("e_busy_after_rst", busy, 0);
    for (int k = 5; k <= 20; k++) begin
      tick();
      idle_inputs();
      req1_valid = (k == 5);
      if (k == 13) begin dec_valid = 1'b1; dec_data = 4'hA; dec_syndrome = 3'b000; end
    end
    tick(); idle_inputs();
    check("e_grant_count", gnt_log.size(), 2);
    check("e_bit_count", bits_log.size(), 10);
    check("e_rsp_count", rsp_log.size(), 1);
    if (rsp_log.size() > 0) begin
      check("e_rsp_id", rsp_log[0].id, 1);
      check("e_rsp_data", rsp_log[0].data, 4'hA);
    end

    // 300 error responses: err_count must stop at 255.
    do_reset(); clear_logs();
    for (int k = 0; k <= 3005; k++) begin
      if (k > 0) tick();
      idle_inputs();
      req0_valid = 1'b1; dec_valid = 1'b1; dec_syndrome = 3'b101;
    end
    tick(); idle_inputs();
    check("f_rsp_count", rsp_log.size() >= 300, 1);
    @(negedge clk);
    check("f_err_sat", err_count, 255);

    // Random traffic against the model, with occasional resets.
    do_reset(); clear_logs();
    for (int k = 0; k < 4000; k++) begin
      tick();
      idle_inputs();
      rst          = ($urandom_range(0, 399) == 0);
      req0_valid   = ($urandom_range(0, 2) == 0);
      req1_valid   = ($urandom_range(0, 2) == 0);
      dec_valid    = ($urandom_range(0, 5) == 0);
      dec_syndrome = ($urandom_range(0, 1) == 0) ? 3'b000 : 3'($urandom);
    end
    tick(); idle_inputs();
    repeat (3) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule

// File: doc/hamming_decode_scheduler.md
HAMMING_DECODE_SCHEDULER -- requirements
Module: hamming_decode_scheduler

Interface
REQ-001 The block SHALL have parameter TIMEOUT, default 15: maximum WAIT cycles for a decoder result, legal range 1-255.
REQ-002 The block SHALL have port clk, input, 1 bit: single clock; all logic on the rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 The block SHALL have port req0_valid, input, 1 bit: requester 0 presents a codeword.
REQ-005 The block SHALL have port req0_code, input, 7 bits: requester 0 Hamming(7,4) codeword.
REQ-006 The block SHALL have port req0_ready, output, 1 bit: requester 0 codeword accepted this cycle.
REQ-007 The block SHALL have ports req1_valid, req1_code and req1_ready, with widths and meanings identical to REQ-004..006, for requester 1.
REQ-008 The block SHALL have port dec_ena, output, 1 bit: enable to the shared bit-serial decoder.
REQ-009 The block SHALL have port dec_bit, output, 1 bit: serial codeword bit to the decoder.
REQ-010 The block SHALL have port dec_valid, input, 1 bit: decoder result valid.
REQ-011 The block SHALL have port dec_data, input, 4 bits: decoded nibble.
REQ-012 The block SHALL have port dec_syndrome, input, 3 bits: decoder syndrome.
REQ-013 The block SHALL have port rsp_valid, output, 1 bit: one-cycle response pulse.
REQ-014 The block SHALL have port rsp_id, output, 1 bit: requester that owns the response.
REQ-015 The block SHALL have port rsp_data, output, 4 bits: decoded nibble returned.
REQ-016 The block SHALL have port rsp_err, output, 1 bit: captured syndrome was nonzero.
REQ-017 The block SHALL have port rsp_timeout, output, 1 bit: decoder did not answer within TIMEOUT cycles.
REQ-018 The block SHALL have port err_count, output, 8 bits: saturating count of responses with rsp_err set.
REQ-019 The block SHALL have port busy, output, 1 bit: high in every state except IDLE.

Function
REQ-020 The block SHALL implement FSM states IDLE, SHIFT, WAIT and RESP.
REQ-021 In IDLE with any reqN_valid high, the block SHALL grant per REQ-022 and assert that reqN_ready for exactly this one cycle.
REQ-022 The block SHALL arbitrate round-robin: a single valid requester wins; if both are valid, the requester not granted last wins.
REQ-023 In the grant cycle, the block SHALL latch the granted codeword and its id, and go to SHIFT.
REQ-024 In SHIFT, the block SHALL drive dec_ena=1 and dec_bit=code[i] for i=0..6, one bit per cycle LSB first (7 cycles), then go to WAIT.
REQ-025 Outside SHIFT, the block SHALL hold dec_ena=0 and dec_bit=0.
REQ-026 In WAIT, the block SHALL increment a wait counter each cycle.
REQ-027 In WAIT, on dec_valid=1 the block SHALL latch dec_data and (dec_syndrome!=0), then go to RESP.
REQ-028 In WAIT, if the counter reaches TIMEOUT without dec_valid, the block SHALL go to RESP with rsp_timeout=1, rsp_data=0 and rsp_err=0.
REQ-029 The block SHALL ignore dec_valid in IDLE, SHIFT and RESP.
REQ-030 If dec_valid arrives in the same cycle the counter reaches TIMEOUT, the block SHALL treat it as a valid result, not a timeout.
REQ-031 In RESP, the block SHALL assert rsp_valid for one cycle with rsp_id, rsp_data, rsp_err and rsp_timeout, then go to IDLE.
REQ-032 rsp_* SHALL have no backpressure.
REQ-033 Outside RESP, the block SHALL drive rsp_valid=0 and rsp_data, rsp_err, rsp_timeout and rsp_id to 0.
REQ-034 Latency SHALL be: grant at cycle T, dec_ena high T+1..T+7, WAIT from T+8, earliest rsp_valid at T+9 (dec_valid at T+8).
REQ-035 A new grant SHALL be possible no earlier than the cycle after RESP.
REQ-036 The block SHALL never assert both reqN_ready in one cycle, and never assert reqN_ready outside IDLE.
REQ-037 err_count SHALL increment in the RESP cycle when rsp_err=1, and saturate at 255.
REQ-038 A timeout response SHALL never increment err_count.
REQ-039 Requests deasserted before grant SHALL be dropped without effect; a codeword changing after acceptance SHALL not affect the latched copy.

Reset
REQ-040 On rst=1 at a clock edge, the block SHALL enter IDLE and clear the wait counter, bit index and err_count.
REQ-041 On reset, the block SHALL set the round-robin pointer so that requester 0 wins the next tie.
REQ-042 On reset, all outputs SHALL be 0: req0_ready, req1_ready, dec_ena, dec_bit, rsp_*, err_count and busy.
REQ-043 Reset mid-SHIFT/WAIT/RESP SHALL abort the transaction with no response pulse.
REQ-044 rst SHALL take priority over all other inputs in the same cycle.

Verification
REQ-045 The bench SHALL cover: req0 code 7'b1010101 alone -> req0_ready 1 cycle; dec_bit sequence 1,0,1,0,1,0,1 over 7 cycles; dec_valid data 4'hB syndrome 0 -> rsp_valid, rsp_id=0, rsp_data=4'hB, rsp_err=0.
REQ-046 The bench SHALL cover: both requesters valid continuously after reset -> grants 0,1,0,1; rsp_id alternates.
REQ-047 The bench SHALL cover: decoder silent, TIMEOUT=15 -> rsp_valid exactly 15 cycles after WAIT entry, rsp_timeout=1, rsp_data=0, err_count unchanged.
REQ-048 The bench SHALL cover: 300 responses with syndrome 3'b101 -> err_count=255, no wrap.
REQ-049 The bench SHALL cover: rst asserted at third SHIFT cycle -> next cycle dec_ena=0, busy=0, no rsp_valid; a following req1 is granted normally.
REQ-050 The bench SHALL cover: dec_valid pulsed during SHIFT, then real result in WAIT -> response carries the WAIT result only.
